// File: rtl/pc_sequencer_pkg.sv
// Shared types and decode constants for the program-counter stage.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_ABS  = 2'b01,
    SEL_PAGE = 2'b10,
    SEL_REL  = 2'b11
  } jump_sel_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target candidates and the decode choosing which
// one is latched for the instruction currently in EXEC.
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction_word,
  input  logic [31:0] rs_data,
  output logic [31:0] pc4,
  output logic [31:0] target
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [31:0] page_s;
  logic [31:0] rel_s;

  assign opcode_s = instruction_word[31:26];
  assign funct_s  = instruction_word[5:0];
  assign pc4      = pc + 32'd4;
  assign page_s   = {pc4[31:28], instruction_word[25:0], 2'b00};
  assign rel_s    = pc4 + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};

  // Register jumps take rs, J/JAL take the page target, everything else the relative one.
  always_comb begin
    target = rel_s;
    if ((opcode_s == OP_SPECIAL) && ((funct_s == FN_JR) || (funct_s == FN_JALR))) begin
      target = rs_data;
    end else if ((opcode_s == OP_J) || (opcode_s == OP_JAL)) begin
      target = page_s;
    end else begin
      target = rel_s;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with one branch-delay slot, halt-on-jump-to-zero and link value.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        state,
  input  logic        stall,
  input  logic [31:0] instruction_word,
  input  logic [31:0] rs_data,
  input  logic [1:0]  jump_addr_selection,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        active
);

  seq_state_t  fsm_r, fsm_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] target_r, target_next_s;
  logic        active_r, active_next_s;
  logic [31:0] pc4_s;
  logic [31:0] cand_target_s;
  logic [31:0] jump_pc_s;
  logic        commit_s;

  pc_target_calc u_target_calc (
    .pc               (pc_r),
    .instruction_word (instruction_word),
    .rs_data          (rs_data),
    .pc4              (pc4_s),
    .target           (cand_target_s)
  );

  assign commit_s = state && !stall;

  // Old target_r steers the delay-slot commit while the new one is captured.
  always_comb begin
    fsm_next_s    = fsm_r;
    pc_next_s     = pc_r;
    target_next_s = target_r;
    active_next_s = active_r;
    jump_pc_s     = pc4_s;
    if (jump_sel_t'(jump_addr_selection) != SEL_NONE) begin
      jump_pc_s = target_r;
    end else begin
      jump_pc_s = pc4_s;
    end
    case (fsm_r)
      ST_RUN: begin
        if (commit_s) begin
          pc_next_s     = jump_pc_s;
          target_next_s = cand_target_s;
          if (jump_pc_s == HALT_ADDR) begin
            fsm_next_s    = ST_HALTED;
            active_next_s = 1'b0;
          end else begin
            fsm_next_s    = ST_RUN;
            active_next_s = 1'b1;
          end
        end else begin
          pc_next_s = pc_r;
        end
      end
      ST_HALTED: begin
        active_next_s = 1'b0;
      end
      default: begin
        fsm_next_s    = ST_HALTED;
        active_next_s = 1'b0;
      end
    endcase
  end

  // State, PC, pending target and run flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r    <= ST_RUN;
      pc_r     <= RESET_VECTOR;
      target_r <= 32'h00000000;
      active_r <= 1'b1;
    end else begin
      fsm_r    <= fsm_next_s;
      pc_r     <= pc_next_s;
      target_r <= target_next_s;
      active_r <= active_next_s;
    end
  end

  assign pc       = pc_r;
  assign active   = active_r;
  assign pc_plus8 = pc_r + 32'd8;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: delay-slot jumps, stall, reset and halt.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        state;
  logic        stall;
  logic [31:0] instruction_word;
  logic [31:0] rs_data;
  logic [1:0]  jump_addr_selection;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        active;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP   = 32'h00000000;
  localparam logic [31:0] BEQ_M = 32'h1000FFFC;
  localparam logic [31:0] BEQ_P = 32'h10000010;
  localparam logic [31:0] J_100 = 32'h08000100;
  localparam logic [31:0] J_200 = 32'h08000200;
  localparam logic [31:0] JR    = 32'h03E00008;
  localparam logic [31:0] JALR  = 32'h03E0F809;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .state               (state),
    .stall               (stall),
    .instruction_word    (instruction_word),
    .rs_data             (rs_data),
    .jump_addr_selection (jump_addr_selection),
    .pc                  (pc),
    .pc_plus8            (pc_plus8),
    .active              (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from the falling edge and return at the next falling edge.
  task automatic step(input logic rst, input logic st, input logic stl,
                      input logic [31:0] instr, input logic [31:0] rs, input logic [1:0] sel);
    reset               = rst;
    state               = st;
    stall               = stl;
    instruction_word    = instr;
    rs_data             = rs;
    jump_addr_selection = sel;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; state = 1'b0; stall = 1'b0;
    instruction_word = NOP; rs_data = 32'h0; jump_addr_selection = 2'b00;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    check("reset_pc", pc, 32'hBFC00000);
    check("reset_active", {31'd0, active}, 32'd1);
    check("reset_pc8", pc_plus8, 32'hBFC00008);

    step(1'b0, 1'b0, 1'b0, NOP, 32'h0, 2'b00);
    check("fetch_hold", pc, 32'hBFC00000);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    check("seq3_pc", pc, 32'hBFC0000C);
    check("seq3_pc8", pc_plus8, 32'hBFC00014);

    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    step(1'b0, 1'b1, 1'b0, BEQ_M, 32'h0, 2'b00);
    check("beq_commit", pc, 32'hBFC00014);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b11);
    check("beq_taken", pc, 32'hBFC00004);

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    check("walk_pc", pc, 32'hBFC00020);
    step(1'b0, 1'b1, 1'b0, J_100, 32'h0, 2'b00);
    check("j_commit", pc, 32'hBFC00024);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b10);
    check("j_taken", pc, 32'hB0000400);
    check("j_pc8", pc_plus8, 32'hB0000408);

    step(1'b0, 1'b1, 1'b0, BEQ_P, 32'h0, 2'b00);
    check("beq2_commit", pc, 32'hB0000404);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, J_200, 32'h55555555, 2'b11);
    check("stall_hold", pc, 32'hB0000404);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b11);
    check("stall_release", pc, 32'hB0000444);

    step(1'b0, 1'b1, 1'b0, JR, 32'h12345678, 2'b00);
    check("jr_commit", pc, 32'hB0000448);
    step(1'b1, 1'b1, 1'b0, NOP, 32'h0, 2'b01);
    check("rst_mid_pc", pc, 32'hBFC00000);
    check("rst_mid_active", {31'd0, active}, 32'd1);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    check("rst_no_jump", pc, 32'hBFC00004);

    step(1'b0, 1'b1, 1'b0, JR, 32'hFFFFFFFC, 2'b00);
    check("jr2_commit", pc, 32'hBFC00008);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b01);
    check("jr2_taken", pc, 32'hFFFFFFFC);
    check("pc8_wrap", pc_plus8, 32'h00000004);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h0, 2'b00);
    check("wrap_halt_pc", pc, 32'h00000000);
    check("wrap_halt_active", {31'd0, active}, 32'd0);

    step(1'b1, 1'b0, 1'b0, NOP, 32'h0, 2'b00);
    check("reset2_active", {31'd0, active}, 32'd1);
    step(1'b0, 1'b1, 1'b0, JALR, 32'h00000000, 2'b00);
    check("jalr_commit", pc, 32'hBFC00004);
    step(1'b0, 1'b1, 1'b0, NOP, 32'h00000000, 2'b01);
    check("halt_pc", pc, 32'h00000000);
    check("halt_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, i[0], JALR, 32'hA5A5A5A4, 2'b01);
    check("halted_pc", pc, 32'h00000000);
    check("halted_active", {31'd0, active}, 32'd0);
    check("halted_pc8", pc_plus8, 32'h00000008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch/jump decision logic.
- Consumes the registered 2-bit jump_addr_selection code and computes the next PC, with one architectural branch-delay slot.
- Latches the jump/branch target from the branch instruction and applies it after the delay slot.
- Detects jump-to-zero as CPU halt, drives active low, and supplies the fetch address and the link value PC+8.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, committed next-PC value that halts the CPU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- state  input  1  0 = FETCH, 1 = EXEC; PC commits only at the end of EXEC.
- stall  input  1  high = hold PC and target (memory wait); no commit.
- instruction_word  input  32  instruction currently in EXEC.
- rs_data  input  32  register rs read value (JR/JALR target).
- jump_addr_selection  input  2  00 none, 01 absolute, 10 page absolute, 11 PC-relative; already delayed to apply to the delay-slot cycle.
- pc  output  32  current fetch address.
- pc_plus8  output  32  link value for JAL/JALR/BxxAL, combinational pc+8.
- active  output  1  high while the CPU runs; low once halted.

Behaviour:
- Reset (sync, active-high, overrides all): pc=RESET_VECTOR, target_q=0, FSM=RUN, active=1.
- Commit edge = posedge clk with state=1, stall=0, FSM≠HALTED; no register changes on any other edge.
- Target candidates, computed from the current pc and instruction_word, with pc4 = pc+4 (mod 2^32):
  - abs = rs_data.
  - page = {pc4[31:28], instr[25:0], 2'b00}.
  - rel = pc4 + (sign-extend(instr[15:0]) << 2), 32-bit wrap-around.
- target_q captured on every commit edge:
  - rs_data if opcode=0 and funct ∈ {001000, 001001}.
  - page if opcode ∈ {000010, 000011}.
  - otherwise rel.
  - Captured regardless of branch outcome; used only if selection≠00 on the next commit.
- pc_next on a commit edge:
  - If jump_addr_selection≠00: pc_next = target_q, the value latched at the previous commit (the branch itself); the current instruction is the delay slot.
  - Else: pc_next = pc4.
- Same-cycle capture and use: target_q is written with the current instruction's target while the old target_q drives pc_next (read-before-write). A branch in a delay slot therefore works as a 1-deep pipeline; no special case.
- pc_plus8 = pc+8, wrapping past 32'hFFFFFFF8.
- FSM:
  - RUN: on a commit edge, if pc_next==HALT_ADDR: pc<=HALT_ADDR, FSM<=HALTED, active<=0 at the same edge. Otherwise pc<=pc_next.
  - HALTED: pc and target_q frozen, active=0, state/stall ignored. Exit only via reset.
- Stall during EXEC: no commit, pc and target_q held; commit occurs on the first EXEC edge with stall=0.
- Reset mid-delay-slot: the pending target is discarded and execution restarts at RESET_VECTOR.
- No alignment checking: low 2 bits of abs are passed through unchanged.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - typedef jump_sel_t, an enum of the 4 selection codes.
  - Opcode constants OP_SPECIAL=6'b000000, OP_J=6'b000010, OP_JAL=6'b000011.
  - Funct constants FN_JR=6'b001000, FN_JALR=6'b001001.
  - FSM enum {RUN, HALTED}.
- Sub-module: pc_target_calc, combinational target select for abs/page/rel plus capture-select decode. Everything else stays in pc_sequencer.

Test Plan:
- Reset → pc=BFC00000, active=1. Three EXEC commits with sel=00 → pc=BFC0000C; pc_plus8=BFC00014.
- BEQ at pc=BFC00010 with imm=16'hFFFC, then sel=11 on the delay slot (pc=BFC00014) → pc=BFC00004 after the delay-slot commit; the BEQ commit itself gave BFC00014.
- J at pc=BFC00020 with index=26'h0000100, sel=10 next → pc=B0000400 after the delay slot.
- JR with rs_data=0 then sel=01 → the delay slot commits, pc=0, active=0 on the same edge; 10 further EXEC cycles → pc stays 0, active stays 0.
- stall=1 for 3 EXEC cycles during a pending branch (sel=11) → pc and target unchanged; first unstalled EXEC → pc=target.
- Reset asserted in the delay-slot EXEC with sel=01 → pc=BFC00000, active=1, and no jump on the subsequent commit with sel=00.
